// File: rtl/sfm_multirow_ctrl.sv
// Multi-row softmax job controller.
// Steps a job of n_rows rows through the streamers and the datapath. Each row
// goes through accumulate -> drain -> reduce -> divide. In accumulate-only
// mode the divide pass is skipped.
//
// Handshake semantics: every *_done_i, dp_reducing_i and start_i input is a
// single-cycle pulse. The controller only acts on a pulse while it is in the
// state that waits for that pulse; pulses in any other state are dropped.
// in_start_o, out_start_o and done_o are single-cycle pulses.
// acc_finished_o and dividing_o are levels. They also fall combinationally in
// the cycle that the matching handshake (dp_reducing_i, out_done_i) arrives.
module sfm_multirow_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int ROW_WIDTH  = 16,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [ADDR_WIDTH-1:0] in_base_i,
    input  logic [ADDR_WIDTH-1:0] out_base_i,
    input  logic [ADDR_WIDTH-1:0] in_stride_i,
    input  logic [ADDR_WIDTH-1:0] out_stride_i,
    input  logic [LEN_WIDTH-1:0]  row_len_i,
    input  logic [ROW_WIDTH-1:0]  n_rows_i,
    input  logic                  in_done_i,
    input  logic                  out_done_i,
    input  logic                  dp_busy_i,
    input  logic                  dp_reducing_i,
    output logic                  in_start_o,
    output logic                  out_start_o,
    output logic [ADDR_WIDTH-1:0] in_addr_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [LEN_WIDTH-1:0]  tot_len_o,
    output logic [ADDR_WIDTH-1:0] d0_stride_o,
    output logic                  acc_finished_o,
    output logic                  dividing_o,
    output logic [ROW_WIDTH-1:0]  row_idx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [2:0] {
        IDLE, ROW_START, ACCUMULATION, WAIT_EMPTY,
        WAIT_REDUCE, DIVIDING, NEXT_ROW, DONE
    } state_t;

    state_t                state_q;
    logic                  mode_q;
    logic                  in_start_q;
    logic                  out_start_q;
    logic [ADDR_WIDTH-1:0] in_addr_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [ADDR_WIDTH-1:0] in_stride_q;
    logic [ADDR_WIDTH-1:0] out_stride_q;
    logic [LEN_WIDTH-1:0]  tot_len_q;
    logic [ROW_WIDTH-1:0]  n_rows_q;
    logic [ROW_WIDTH-1:0]  row_idx_q;

    // Job sequencing, config latching and row pointer stepping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            in_start_q   <= 1'b0;
            out_start_q  <= 1'b0;
            in_addr_q    <= '0;
            out_addr_q   <= '0;
            in_stride_q  <= '0;
            out_stride_q <= '0;
            tot_len_q    <= '0;
            n_rows_q     <= '0;
            row_idx_q    <= '0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            in_start_q   <= 1'b0;
            out_start_q  <= 1'b0;
            in_addr_q    <= '0;
            out_addr_q   <= '0;
            in_stride_q  <= '0;
            out_stride_q <= '0;
            tot_len_q    <= '0;
            n_rows_q     <= '0;
            row_idx_q    <= '0;
        end else begin
            in_start_q  <= 1'b0;
            out_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q       <= mode_i;
                        in_addr_q    <= in_base_i;
                        out_addr_q   <= out_base_i;
                        in_stride_q  <= in_stride_i;
                        out_stride_q <= out_stride_i;
                        tot_len_q    <= row_len_i;
                        n_rows_q     <= n_rows_i;
                        row_idx_q    <= '0;
                        if (n_rows_i == '0 || row_len_i == '0) begin
                            state_q <= DONE;
                        end else begin
                            in_start_q <= 1'b1;
                            state_q    <= ROW_START;
                        end
                    end
                end
                ROW_START:    state_q <= ACCUMULATION;
                ACCUMULATION: if (in_done_i) state_q <= WAIT_EMPTY;
                WAIT_EMPTY:   if (!dp_busy_i) state_q <= WAIT_REDUCE;
                WAIT_REDUCE: begin
                    if (dp_reducing_i) begin
                        if (!mode_q) begin
                            in_start_q  <= 1'b1;
                            out_start_q <= 1'b1;
                            state_q     <= DIVIDING;
                        end else begin
                            state_q <= NEXT_ROW;
                        end
                    end
                end
                DIVIDING:     if (out_done_i) state_q <= NEXT_ROW;
                NEXT_ROW: begin
                    if (row_idx_q == n_rows_q - ROW_WIDTH'(1)) begin
                        state_q <= DONE;
                    end else begin
                        row_idx_q  <= row_idx_q + ROW_WIDTH'(1);
                        in_addr_q  <= in_addr_q + in_stride_q;
                        out_addr_q <= out_addr_q + out_stride_q;
                        in_start_q <= 1'b1;
                        state_q    <= ROW_START;
                    end
                end
                DONE:         state_q <= IDLE;
                default:      state_q <= IDLE;
            endcase
        end
    end

    // Output decode: pulses come from registers, levels from the state register.
    always_comb begin
        in_start_o     = in_start_q;
        out_start_o    = out_start_q;
        in_addr_o      = in_addr_q;
        out_addr_o     = out_addr_q;
        tot_len_o      = tot_len_q;
        row_idx_o      = row_idx_q;
        d0_stride_o    = ADDR_WIDTH'(DATA_WIDTH / 8);
        busy_o         = (state_q != IDLE) && (state_q != DONE);
        done_o         = (state_q == DONE);
        acc_finished_o = ((state_q == WAIT_EMPTY) && !dp_busy_i) ||
                         ((state_q == WAIT_REDUCE) && !dp_reducing_i);
        dividing_o     = (state_q == DIVIDING) && !out_done_i;
    end

endmodule

// File: tb/tb_sfm_multirow_ctrl.sv
// Directed bench for sfm_multirow_ctrl. Inputs change just after the falling
// edge. Outputs are sampled mid-cycle, after the rising edge has settled.
module tb_sfm_multirow_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic        start_i;
  logic        mode_i;
  logic [31:0] in_base_i;
  logic [31:0] out_base_i;
  logic [31:0] in_stride_i;
  logic [31:0] out_stride_i;
  logic [31:0] row_len_i;
  logic [15:0] n_rows_i;
  logic        in_done_i;
  logic        out_done_i;
  logic        dp_busy_i;
  logic        dp_reducing_i;
  logic        in_start_o;
  logic        out_start_o;
  logic [31:0] in_addr_o;
  logic [31:0] out_addr_o;
  logic [31:0] tot_len_o;
  logic [31:0] d0_stride_o;
  logic        acc_finished_o;
  logic        dividing_o;
  logic [15:0] row_idx_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;

  sfm_multirow_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .mode_i(mode_i), .in_base_i(in_base_i), .out_base_i(out_base_i),
    .in_stride_i(in_stride_i), .out_stride_i(out_stride_i),
    .row_len_i(row_len_i), .n_rows_i(n_rows_i), .in_done_i(in_done_i),
    .out_done_i(out_done_i), .dp_busy_i(dp_busy_i),
    .dp_reducing_i(dp_reducing_i), .in_start_o(in_start_o),
    .out_start_o(out_start_o), .in_addr_o(in_addr_o),
    .out_addr_o(out_addr_o), .tot_len_o(tot_len_o),
    .d0_stride_o(d0_stride_o), .acc_finished_o(acc_finished_o),
    .dividing_o(dividing_o), .row_idx_o(row_idx_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next cycle.
  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  task automatic configure(input logic m, input logic [31:0] ib, ob, is, os, len,
                           input logic [15:0] nr);
    mode_i = m; in_base_i = ib; out_base_i = ob; in_stride_i = is;
    out_stride_i = os; row_len_i = len; n_rows_i = nr;
  endtask

  // Pulse start; return in the first cycle after the start edge.
  task automatic kick();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    #1;
  endtask

  // Run one row starting in its ROW_START cycle. busy_hold keeps dp_busy_i
  // high for that many WAIT_EMPTY cycles, and a stray start is tried there.
  task automatic run_row(input logic m, input logic [31:0] ein, eout,
                         input logic [15:0] eidx, input logic last, input int busy_hold);
    logic acc_seen;
    check("row_in_start", {31'd0, in_start_o}, 32'd1);
    check("row_out_start", {31'd0, out_start_o}, 32'd0);
    check("row_busy", {31'd0, busy_o}, 32'd1);
    check("row_in_addr", in_addr_o, ein);
    check("row_out_addr", out_addr_o, eout);
    check("row_idx", {16'd0, row_idx_o}, {16'd0, eidx});
    cyc();
    check("acc_in_start_low", {31'd0, in_start_o}, 32'd0);
    check("acc_fin_low", {31'd0, acc_finished_o}, 32'd0);
    if (busy_hold > 0) dp_busy_i = 1'b1;
    in_done_i = 1'b1;
    cyc();
    in_done_i = 1'b0;
    acc_seen = 1'b0;
    for (int i = 0; i < busy_hold; i++) begin
      if (i == 0) begin
        start_i = 1'b1; in_base_i = 32'hDEAD0000; n_rows_i = 16'd0;
      end
      #1;
      acc_seen = acc_seen | acc_finished_o;
      cyc();
      start_i = 1'b0;
    end
    if (busy_hold > 0) begin
      check("hold_acc_fin", {31'd0, acc_seen}, 32'd0);
      check("hold_in_addr", in_addr_o, ein);
      check("hold_busy", {31'd0, busy_o}, 32'd1);
    end
    dp_busy_i = 1'b0;
    #1;
    check("empty_acc_fin", {31'd0, acc_finished_o}, 32'd1);
    cyc();
    check("reduce_acc_fin", {31'd0, acc_finished_o}, 32'd1);
    dp_reducing_i = 1'b1;
    #1;
    check("reduce_ack_acc_fin", {31'd0, acc_finished_o}, 32'd0);
    cyc();
    dp_reducing_i = 1'b0;
    #1;
    if (!m) begin
      check("div_in_start", {31'd0, in_start_o}, 32'd1);
      check("div_out_start", {31'd0, out_start_o}, 32'd1);
      check("div_dividing", {31'd0, dividing_o}, 32'd1);
      in_done_i = 1'b1;
      cyc();
      in_done_i = 1'b0;
      #1;
      check("div_pulse_end", {31'd0, out_start_o}, 32'd0);
      check("div_ignore_in_done", {31'd0, dividing_o}, 32'd1);
      out_done_i = 1'b1;
      #1;
      check("div_ack_low", {31'd0, dividing_o}, 32'd0);
      cyc();
      out_done_i = 1'b0;
      #1;
    end else begin
      check("m1_out_start", {31'd0, out_start_o}, 32'd0);
      check("m1_dividing", {31'd0, dividing_o}, 32'd0);
    end
    check("next_busy", {31'd0, busy_o}, 32'd1);
    check("next_done", {31'd0, done_o}, 32'd0);
    check("next_in_addr", in_addr_o, ein);
    cyc();
    if (last) begin
      check("job_done", {31'd0, done_o}, 32'd1);
      check("job_done_busy", {31'd0, busy_o}, 32'd0);
      cyc();
      check("job_done_pulse", {31'd0, done_o}, 32'd0);
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; in_done_i = 1'b0;
    out_done_i = 1'b0; dp_busy_i = 1'b0; dp_reducing_i = 1'b0;
    configure(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    cyc(); cyc();
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_in_addr", in_addr_o, 32'h0);
    check("rst_tot_len", tot_len_o, 32'h0);
    check("d0_stride", d0_stride_o, 32'd16);
    rst_i = 1'b0;
    cyc();

    // single row, full softmax
    configure(1'b0, 32'h1000, 32'h2000, 32'h0, 32'h0, 32'd64, 16'd1);
    kick();
    check("t1_tot_len", tot_len_o, 32'd64);
    run_row(1'b0, 32'h1000, 32'h2000, 16'd0, 1'b1, 0);

    // three rows with independent strides
    configure(1'b0, 32'h1000, 32'h2000, 32'h100, 32'h200, 32'd8, 16'd3);
    kick();
    run_row(1'b0, 32'h1000, 32'h2000, 16'd0, 1'b0, 0);
    run_row(1'b0, 32'h1100, 32'h2200, 16'd1, 1'b0, 0);
    run_row(1'b0, 32'h1200, 32'h2400, 16'd2, 1'b1, 0);

    // accumulate-only, two rows
    configure(1'b1, 32'h3000, 32'h4000, 32'h40, 32'h40, 32'd4, 16'd2);
    kick();
    run_row(1'b1, 32'h3000, 32'h4000, 16'd0, 1'b0, 0);
    run_row(1'b1, 32'h3040, 32'h4040, 16'd1, 1'b1, 0);

    // zero rows and zero length finish with no stream starts
    configure(1'b0, 32'h1000, 32'h2000, 32'h0, 32'h0, 32'd64, 16'd0);
    kick();
    check("nr0_done", {31'd0, done_o}, 32'd1);
    check("nr0_in_start", {31'd0, in_start_o}, 32'd0);
    check("nr0_busy", {31'd0, busy_o}, 32'd0);
    cyc();
    check("nr0_idle", {31'd0, done_o}, 32'd0);
    configure(1'b0, 32'h1000, 32'h2000, 32'h0, 32'h0, 32'd0, 16'd4);
    kick();
    check("len0_done", {31'd0, done_o}, 32'd1);
    check("len0_in_start", {31'd0, in_start_o}, 32'd0);
    cyc();

    // pointer wrap, plus drain hold and a stray start while busy
    configure(1'b1, 32'hFFFFFF00, 32'h0, 32'h100, 32'h10, 32'd16, 16'd2);
    kick();
    run_row(1'b1, 32'hFFFFFF00, 32'h0, 16'd0, 1'b0, 10);
    run_row(1'b1, 32'h00000000, 32'h10, 16'd1, 1'b1, 0);

    // clear during DIVIDING
    configure(1'b0, 32'h5000, 32'h6000, 32'h0, 32'h0, 32'd32, 16'd1);
    kick();
    cyc();
    in_done_i = 1'b1; cyc(); in_done_i = 1'b0;
    cyc();
    dp_reducing_i = 1'b1; cyc(); dp_reducing_i = 1'b0;
    #1;
    check("clr_pre_dividing", {31'd0, dividing_o}, 32'd1);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    #1;
    check("clr_dividing", {31'd0, dividing_o}, 32'd0);
    check("clr_busy", {31'd0, busy_o}, 32'd0);
    check("clr_in_addr", in_addr_o, 32'h0);
    check("clr_out_addr", out_addr_o, 32'h0);
    check("clr_tot_len", tot_len_o, 32'h0);
    begin
      logic done_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        done_seen = done_seen | done_o;
        cyc();
      end
      check("clr_no_done", {31'd0, done_seen}, 32'd0);
    end

    // asynchronous reset mid-ACCUMULATION
    configure(1'b0, 32'h7000, 32'h8000, 32'h0, 32'h0, 32'd32, 16'd2);
    kick();
    cyc();
    check("arst_pre_busy", {31'd0, busy_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_in_addr", in_addr_o, 32'h0);
    check("arst_tot_len", tot_len_o, 32'h0);
    cyc();
    rst_i = 1'b0;
    cyc();
    check("arst_no_done", {31'd0, done_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
